// File: rtl/ili9341_spi_decoder.sv
// ILI9341 4-wire SPI link monitor: oversamples CS_N/SCK/MOSI/DC on clk, rebuilds
// {dc, byte} words into a small FWFT FIFO and tracks command, parameter index and
// RAMWR pixel/frame progress.
module ili9341_spi_decoder #(
  parameter int SYNC_STAGES      = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int PIXELS_PER_FRAME = 76800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  output logic [8:0]  word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        overflow_o,
  output logic [7:0]  cmd_o,
  output logic [5:0]  param_idx_o,
  output logic        ramwr_active_o,
  output logic [16:0] pixel_cnt_o,
  output logic        frame_done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [16:0]   PIX_LAST  = 17'(PIXELS_PER_FRAME - 1);
  localparam logic [7:0]    CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {IDLE, CMD, RAMWR} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, dc_sync;
  logic cs_s, sck_s, mosi_s, dc_s;

  // Bring the asynchronous SPI pins into the clk domain; reset parks them idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    if (!rst_n) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   spi_dc};
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Bit assembly
  // ---------------------------------------------------------------------------
  logic       sck_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       byte_stb;
  logic [8:0] byte_word;
  logic       sck_rise;

  assign sck_rise = sck_s & ~sck_q & ~cs_s;

  // Shift MOSI on each framed SCK rise; the 8th bit strobes a finished word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q     <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      byte_stb  <= 1'b0;
      byte_word <= 9'd0;
    end else begin
      sck_q    <= sck_s;
      byte_stb <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_stb  <= 1'b1;
          byte_word <= {dc_s, shift_reg[6:0], mosi_s};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, do_push;

  assign word_valid_o = (count != '0);
  assign pop          = word_valid_o & word_ready_i;
  assign do_push      = byte_stb & ((count != FULL_CNT) | pop);
  assign word_o       = word_valid_o ? mem[rd_ptr] : 9'd0;

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; word_o is masked while
    // empty, so stale entries are never observed and the RAM stays reset-free.
    if (do_push) mem[wr_ptr] <= byte_word;
  end

  // Pointers, fill count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (byte_stb && !do_push) overflow_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command / parameter / RAMWR decode
  // ---------------------------------------------------------------------------
  state_t state;
  logic   toggle;

  assign ramwr_active_o = (state == RAMWR);

  // Decode each completed word, independent of whether the FIFO accepted it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_o        <= 8'd0;
      param_idx_o  <= 6'd0;
      toggle       <= 1'b0;
      pixel_cnt_o  <= 17'd0;
      frame_done_o <= 1'b0;
    end else begin
      // NOTE: default-low first so frame_done_o is a single-cycle pulse.
      frame_done_o <= 1'b0;
      if (byte_stb) begin
        if (!byte_word[8]) begin
          cmd_o       <= byte_word[7:0];
          param_idx_o <= 6'd0;
          toggle      <= 1'b0;
          pixel_cnt_o <= 17'd0;
          state       <= (byte_word[7:0] == CMD_RAMWR) ? RAMWR : CMD;
        end else begin
          if (param_idx_o != 6'd63) param_idx_o <= param_idx_o + 6'd1;
          if (state == RAMWR) begin
            toggle <= ~toggle;
            if (toggle) begin
              if (pixel_cnt_o == PIX_LAST) begin
                pixel_cnt_o  <= 17'd0;
                frame_done_o <= 1'b1;
              end else begin
                pixel_cnt_o <= pixel_cnt_o + 17'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_decoder.sv
// Self-checking bench for ili9341_spi_decoder: a bit-banged SPI master drives
// directed and random traffic; a reference model fills a scoreboard queue that a
// separate monitor drains whenever the DUT hands out a word.
module tb_ili9341_spi_decoder;

  localparam int DEPTH = 4;
  localparam int PPF   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_n, spi_sck, spi_mosi, spi_dc;
  logic [8:0]  word_o;
  logic        word_valid_o, word_ready_i;
  logic        overflow_o;
  logic [7:0]  cmd_o;
  logic [5:0]  param_idx_o;
  logic        ramwr_active_o;
  logic [16:0] pixel_cnt_o;
  logic        frame_done_o;

  ili9341_spi_decoder #(
    .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .PIXELS_PER_FRAME(PPF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .overflow_o(overflow_o), .cmd_o(cmd_o), .param_idx_o(param_idx_o),
    .ramwr_active_o(ramwr_active_o), .pixel_cnt_o(pixel_cnt_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain counts derived from the protocol rules.
  logic [8:0] sb[$];
  int m_cmd, m_cnt, m_ramwr, m_frames, m_ovf;
  int frames_seen = 0;
  bit rand_ready  = 0;

  task automatic model_reset();
    sb.delete();
    m_cmd = 0; m_cnt = 0; m_ramwr = 0; m_ovf = 0;
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] b);
    if (sb.size() < DEPTH) sb.push_back({dc, b});
    else m_ovf = 1;
    if (!dc) begin
      m_cmd = b; m_cnt = 0; m_ramwr = (b == 8'h2C);
    end else begin
      m_cnt++;
      if (m_ramwr && (m_cnt % 2 == 0) && ((m_cnt / 2) % PPF == 0)) m_frames++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cmd"},    cmd_o, m_cmd);
    check({tag, "_param"},  param_idx_o, (m_cnt > 63) ? 63 : m_cnt);
    check({tag, "_ramwr"},  ramwr_active_o, m_ramwr);
    check({tag, "_pixel"},  pixel_cnt_o, m_ramwr ? (m_cnt / 2) % PPF : 0);
    check({tag, "_frames"}, frames_seen, m_frames);
    check({tag, "_ovf"},    overflow_o, m_ovf);
  endtask

  // Monitor: compare every word the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && word_valid_o && word_ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %03h, expected none", word_o);
      end else begin
        check("word", word_o, sb.pop_front());
      end
    end
  end

  // Count frame_done pulses (a stuck pulse shows up as extra counts).
  always @(negedge clk) if (rst_n && frame_done_o) frames_seen++;

  // Inputs change 1 time unit after the rising edge, away from DUT sampling.
  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) word_ready_i = 1'($urandom_range(0, 1));
  endtask

  // SCK period = 8 clk (4 low, 4 high), MSB first, data changes while SCK low.
  task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
    spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = b[7-i];
      repeat (4) tick();
      spi_sck = 1'b1;
      if (n == 8 && i == 7) model_byte(dc, b);
      repeat (4) tick();
    end
    spi_sck = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    send_bits(dc, b, 8);
  endtask

  task automatic cs_set(input logic v);
    spi_cs_n = v;
    repeat (4) tick();
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || word_valid_o) && k < 200) begin
      tick(); k++;
    end
    check({tag, "_drain_left"}, sb.size(), 0);
    check({tag, "_drain_valid"}, word_valid_o, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       dc;
    int         f0;

    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
    word_ready_i = 1'b1;
    m_frames = 0;
    model_reset();
    repeat (3) tick();
    check("rst_valid", word_valid_o, 0);
    check("rst_word",  word_o, 0);
    check_state("rst");
    rst_n = 1'b1;
    tick();

    // Command with parameters; 0x2C as a parameter must not enter RAMWR.
    cs_set(1'b0);
    send(1'b0, 8'hCB);
    send(1'b1, 8'h39); send(1'b1, 8'h2C); send(1'b1, 8'h00);
    send(1'b1, 8'h34); send(1'b1, 8'h02);
    cs_set(1'b1);
    wait_drain("t1");
    check_state("t1");
    check("t1_param_const", param_idx_o, 5);

    // Partial byte dropped by CS rising.
    cs_set(1'b0);
    send_bits(1'b1, 8'hA5, 5);
    cs_set(1'b1);
    cs_set(1'b0);
    send(1'b0, 8'h3A);
    cs_set(1'b1);
    wait_drain("t2");
    check_state("t2");
    check("t2_cmd_const", cmd_o, 8'h3A);

    // RAMWR with a 4-pixel frame: 10 bytes -> one frame, 1 pixel left over.
    f0 = frames_seen;
    cs_set(1'b0);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 10; i++) send(1'b1, 8'($urandom));
    check_state("t4a");
    check("t4_frames_delta", frames_seen - f0, 1);
    check("t4_pixel_const", pixel_cnt_o, 1);
    send(1'b0, 8'h29);
    check_state("t4b");
    cs_set(1'b1);
    wait_drain("t4");

    // Overflow with consumer stalled: 5th word dropped, flag sticks.
    word_ready_i = 1'b0;
    cs_set(1'b0);
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i));
    cs_set(1'b1);
    check("t3_ovf_const", overflow_o, 1);
    check_state("t3a");
    repeat (5) tick();
    word_ready_i = 1'b1;
    wait_drain("t3");
    check_state("t3b");

    // Reset mid-byte during RAMWR.
    cs_set(1'b0);
    send(1'b0, 8'h2C);
    send_bits(1'b1, 8'hFF, 4);
    rst_n = 1'b0;
    tick();
    model_reset();
    check("t5_valid", word_valid_o, 0);
    check("t5_word",  word_o, 0);
    check("t5_fdone", frame_done_o, 0);
    check_state("t5_rst");
    rst_n = 1'b1;
    cs_set(1'b1);
    cs_set(1'b0);
    send(1'b1, 8'h55);
    cs_set(1'b1);
    wait_drain("t5");
    check_state("t5");

    // Ready held high: no overflow.
    cs_set(1'b0);
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i));
    cs_set(1'b1);
    wait_drain("t3c");
    check_state("t3c");

    // Random 200-word stream at the minimum SCK period, random consumer ready.
    rand_ready = 1;
    cs_set(1'b0);
    for (int i = 0; i < 200; i++) begin
      dc = ($urandom_range(0, 4) != 0);
      b  = 8'($urandom);
      if (!dc && $urandom_range(0, 2) == 0) b = 8'h2C;
      send(dc, b);
      check_state("t6");
      if ($urandom_range(0, 9) == 0) begin
        cs_set(1'b1);
        cs_set(1'b0);
      end
    end
    cs_set(1'b1);
    rand_ready = 0;
    word_ready_i = 1'b1;
    wait_drain("t6");
    check_state("t6_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
